// File: rtl/shift_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl_pkg
// Shared definitions for the shift sequence controller:
//   - state_e     : controller FSM states (IDLE, LOAD, SHIFT, DONE)
//   - MODE_*      : S1S0 mode codes of the downstream 194-style register
//   - WORD_W      : parallel word width
//   - shift_mode(): maps a direction flag onto the matching S1S0 code
// ---------------------------------------------------------------------------
package shift_seq_ctrl_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Left shifts move data toward Q[31] (S1S0=10), right shifts toward Q[0].
  function automatic logic [1:0] shift_mode(input logic left);
    if (left) begin
      return MODE_LEFT;
    end else begin
      return MODE_RIGHT;
    end
  endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
// Sequences a downstream 32-bit 194-style shift register: loads a word, then
// shifts it len+1 times in the requested direction while reporting the bit
// that leaves the register each cycle.
//
// Ports
//   clk          in   sole clock, rising edge
//   clear        in   synchronous active-high reset
//   start        in   transfer request, honoured in IDLE only
//   abort        in   synchronous cancel back to IDLE (wins over start)
//   dir_left     in   1 = shift toward Q[31], 0 = shift toward Q[0]
//   len[4:0]     in   number of shifts minus one
//   fill         in   bit injected into the vacated end
//   data_in[31:0]in   word to load
//   q_msb, q_lsb in   Q[31] / Q[0] fed back from the downstream register
//   s1, s0       out  downstream mode (00 hold, 01 right, 10 left, 11 load)
//   pdata[31:0]  out  parallel load word (valid in LOAD)
//   sr, sl       out  downstream serial inputs (right / left)
//   sreg_clear   out  downstream clear, follows clear
//   ser_out      out  bit leaving the register this cycle
//   bit_valid    out  ser_out is a transfer bit
//   busy         out  LOAD or SHIFT in progress
//   done         out  one-cycle completion pulse
//
// Build option
//   SHIFT_SEQ_ROTATE_EN : inject the exiting bit instead of fill (rotate),
//                         so 32 shifts restore the original word.
// ---------------------------------------------------------------------------
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic        abort,
  input  logic        dir_left,
  input  logic [4:0]  len,
  input  logic        fill,
  input  logic [31:0] data_in,
  input  logic        q_msb,
  input  logic        q_lsb,
  output logic        s1,
  output logic        s0,
  output logic [31:0] pdata,
  output logic        sr,
  output logic        sl,
  output logic        sreg_clear,
  output logic        ser_out,
  output logic        bit_valid,
  output logic        busy,
  output logic        done
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [WORD_W-1:0]   word_q,  word_d;
  logic                dir_q,   dir_d;
  logic [CNT_W-1:0]    len_q,   len_d;
  logic                fill_q,  fill_d;

  logic                inj_left;
  logic                inj_right;
  logic [1:0]          mode;

  // State and transfer-parameter registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      word_q  <= {WORD_W{1'b0}};
      dir_q   <= 1'b0;
      len_q   <= {CNT_W{1'b0}};
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
    end
  end

  // Next-state logic; parameters are captured only on an accepted start so
  // input changes during a transfer cannot disturb it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    dir_d   = dir_q;
    len_d   = len_q;
    fill_d  = fill_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            word_d  = data_in;
            dir_d   = dir_left;
            len_d   = len;
            fill_d  = fill;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        LOAD: begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = SHIFT;
        end
        SHIFT: begin
          cnt_d = cnt_q + 5'd1;
          // cnt counts completed shifts minus one, so cnt==len is the last.
          if (cnt_q == len_q) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

`ifdef SHIFT_SEQ_ROTATE_EN
  // Rotate: recirculate the exiting bit; fill is not used in this build.
  logic unused_fill;
  assign unused_fill = fill_q;
  assign inj_left    = q_msb;
  assign inj_right   = q_lsb;
`else
  assign inj_left    = fill_q;
  assign inj_right   = fill_q;
`endif

  // Moore output decode from the registered state.
  always_comb begin
    mode      = MODE_HOLD;
    pdata     = {WORD_W{1'b0}};
    sl        = 1'b0;
    sr        = 1'b0;
    bit_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        mode = MODE_HOLD;
      end
      LOAD: begin
        mode  = MODE_LOAD;
        pdata = word_q;
        busy  = 1'b1;
      end
      SHIFT: begin
        mode      = shift_mode(dir_q);
        bit_valid = 1'b1;
        busy      = 1'b1;
        // Only the serial input on the vacated end carries data.
        if (dir_q) begin
          sl = inj_left;
        end else begin
          sr = inj_right;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        mode = MODE_HOLD;
      end
    endcase
  end

  assign s1         = mode[1];
  assign s0         = mode[0];
  assign sreg_clear = clear;
  // The exiting end is Q[31] on left shifts and Q[0] on right shifts.
  assign ser_out    = dir_q ? q_msb : q_lsb;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl
// Drives shift_seq_ctrl together with a behavioural 32-bit 194-style shift
// register and checks the controller outputs and the register contents
// against expectations computed from the transfer parameters.
// ---------------------------------------------------------------------------
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        clear, start, abort, dir_left, fill;
  logic [4:0]  len;
  logic [31:0] data_in;
  logic        q_msb, q_lsb;
  logic        s1, s0, sr, sl, sreg_clear, ser_out, bit_valid, busy, done;
  logic [31:0] pdata;
  logic [31:0] sreg;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int accepted = 0;

`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  always #5 clk = ~clk;

  shift_seq_ctrl dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .abort      (abort),
    .dir_left   (dir_left),
    .len        (len),
    .fill       (fill),
    .data_in    (data_in),
    .q_msb      (q_msb),
    .q_lsb      (q_lsb),
    .s1         (s1),
    .s0         (s0),
    .pdata      (pdata),
    .sr         (sr),
    .sl         (sl),
    .sreg_clear (sreg_clear),
    .ser_out    (ser_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done)
  );

  // Downstream register model.
  assign q_msb = sreg[31];
  assign q_lsb = sreg[0];
  always @(posedge clk) begin
    if (sreg_clear) sreg <= 32'h0;
    else begin
      case ({s1, s0})
        2'b11:   sreg <= pdata;
        2'b01:   sreg <= {sr, sreg[31:1]};
        2'b10:   sreg <= {sreg[30:0], sl};
        default: sreg <= sreg;
      endcase
    end
  end

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Register contents after n=len+1 shifts, from a 64-bit window of
  // word plus injected bits (fill ones/zeros, or the word itself on rotate).
  function automatic logic [31:0] exp_final(input logic [31:0] w, input bit left,
                                            input logic [4:0] ln, input bit f);
    logic [31:0] fm;
    logic [63:0] win;
    int n;
    n  = int'(ln) + 1;
    fm = f ? 32'hFFFF_FFFF : 32'h0;
    if (left) begin
      win = ROT ? {w, w} : {w, fm};
      return win[63-n -: 32];
    end else begin
      win = ROT ? {w, w} : {fm, w};
      return win[n +: 32];
    end
  endfunction

  task automatic scramble();
    data_in  = $urandom;
    dir_left = 1'($urandom_range(0, 1));
    len      = 5'($urandom_range(0, 31));
    fill     = 1'($urandom_range(0, 1));
  endtask

  task automatic run_xfer(input logic [31:0] w, input bit left, input logic [4:0] ln,
                          input bit f, input bit noisy);
    logic [1:0] exp_mode;
    logic [1:0] exp_slsr;
    exp_mode = left ? 2'b10 : 2'b01;
    @(negedge clk);
    chk("idle_busy", busy, 32'd0);
    start = 1'b1; data_in = w; dir_left = left; len = ln; fill = f;
    @(negedge clk);
    accepted++;
    start = 1'b0;
    if (noisy) scramble();
    chk("load_mode", {s1, s0}, 32'd3);
    chk("load_pdata", pdata, w);
    chk("load_busy", busy, 32'd1);
    for (int i = 0; i <= int'(ln); i++) begin
      @(negedge clk);
      chk("shift_mode", {s1, s0}, exp_mode);
      chk("shift_valid", {bit_valid, busy, done}, 32'd6);
      chk("ser_out", ser_out, left ? w[31-i] : w[i]);
      if (ROT) exp_slsr = left ? {sreg[31], 1'b0} : {1'b0, sreg[0]};
      else     exp_slsr = left ? {f, 1'b0} : {1'b0, f};
      chk("serial_in", {sl, sr}, exp_slsr);
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        scramble();
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", {done, busy, bit_valid}, 32'd4);
    chk("done_mode", {s1, s0}, 32'd0);
    chk("final_reg", sreg, exp_final(w, left, ln, f));
    @(negedge clk);
    chk("done_once", {done, busy}, 32'd0);
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; abort = 1'b0; dir_left = 1'b0;
    len = 5'd0; fill = 1'b0; data_in = 32'h0;

    // Power-on reset for two cycles.
    @(negedge clk);
    @(negedge clk);
    chk("rst_sreg_clear", sreg_clear, 32'd1);
    clear = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {s1, s0, sr, sl, sreg_clear, ser_out, bit_valid, busy, done}, 32'd0);
    chk("rst_pdata", pdata, 32'd0);

    // Directed transfers.
    run_xfer(32'h0000_00A5, 1'b0, 5'd7, 1'b0, 1'b0);
    run_xfer(32'h8000_0001, 1'b1, 5'd31, 1'b1, 1'b0);
    run_xfer(32'h1234_5678, 1'b0, 5'd31, 1'b0, 1'b0);
    if (ROT) chk("rotate_restore", sreg, 32'h1234_5678);
    run_xfer(32'hC3C3_0F0F, 1'b1, 5'd0, 1'b0, 1'b0);

    // Abort together with start on the third SHIFT cycle.
    @(negedge clk);
    start = 1'b1; data_in = 32'hDEAD_BEEF; dir_left = 1'b1; len = 5'd31; fill = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_shift", {s1, s0, busy}, 32'd5);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("abort_idle", {s1, s0, busy, done, bit_valid}, 32'd0);
    abort = 1'b0; start = 1'b0;
    run_xfer(32'h0F0F_00FF, 1'b0, 5'd3, 1'b1, 1'b0);

    // Clear held for two cycles in the middle of a transfer.
    @(negedge clk);
    start = 1'b1; data_in = 32'hFFFF_0000; dir_left = 1'b0; len = 5'd20; fill = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    chk("midrst_state", {s1, s0, busy, done, sreg_clear}, 32'd1);
    @(negedge clk);
    chk("midrst_clear2", {sreg_clear, done}, 32'd2);
    clear = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", {s1, s0, sr, sl, sreg_clear, ser_out, bit_valid, busy, done}, 32'd0);
    chk("midrst_pdata", pdata, 32'd0);

    // Randomized transfers with noisy inputs and stray start pulses.
    for (int k = 0; k < 10; k++) begin
      run_xfer($urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 1'b1);
    end

    @(negedge clk);
    chk("done_pulses", done_seen, accepted);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
  clk  in  1  sole clock; all state updates on rising edge
  clear  in  1  reset, synchronous, active-high
  start  in  1  request a transfer; sampled in IDLE only
  abort  in  1  synchronous cancel; returns to IDLE
  dir_left  in  1  1 = shift toward Q[31] (S1S0=10); 0 = shift toward Q[0] (S1S0=01)
  len  in  5  number of shifts minus 1 (0..31 gives 1..32 shifts)
  fill  in  1  bit injected into the vacated end
  data_in  in  32  word to load
  q_msb  in  1  Q[31] fed back from the downstream shift register
  q_lsb  in  1  Q[0] fed back from the downstream shift register
  s1, s0  out  1 each  mode to the downstream register (00 hold, 01 right, 10 left, 11 load)
  pdata  out  32  parallel load word
  sr, sl  out  1 each  serial inputs of the downstream register
  sreg_clear  out  1  active-high clear to the downstream register
  ser_out  out  1  bit leaving the register this cycle
  bit_valid, busy, done  out  1 each  status
REQ-002 Reset SHALL be synchronous and active-high on port clear; the block SHALL have one clock, clk.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, SHIFT and DONE; outputs SHALL be Moore, decoded from registered state.
REQ-004 In IDLE, when start=1 at an edge, the block SHALL latch data_in, dir_left and len, and go to LOAD.
REQ-005 In LOAD, s1s0 SHALL be 11 and pdata SHALL equal the latched word; the next edge SHALL go to SHIFT with cnt=0.
REQ-006 In SHIFT, s1s0 SHALL be 10 if dir_left, else 01, with bit_valid=1; each edge SHALL increment cnt; the edge where cnt==len SHALL go to DONE.
REQ-007 ser_out SHALL equal q_msb when dir_left, else q_lsb, so that exactly len+1 bits are valid, LSB-first for right shifts and MSB-first for left shifts.
REQ-008 In the fill path, sl SHALL drive the fill bit when shifting left, and sr SHALL drive it when shifting right; the unused serial input SHALL be 0.
REQ-009 In DONE, done=1 for exactly one cycle with s1s0=00; the next state SHALL be IDLE.
REQ-010 busy SHALL be 1 in LOAD and SHIFT only; s1s0 SHALL be 00 in IDLE and DONE.
REQ-011 start SHALL be ignored while busy or done=1; no request SHALL be queued.
REQ-012 abort=1 SHALL force IDLE at the next edge from any state, without asserting done; abort SHALL take priority over start in the same cycle.
REQ-013 Transfer latency from start to done SHALL be len+3 cycles: 1 LOAD, len+1 SHIFT, then done on the following cycle.
REQ-014 Inputs changing during busy SHALL NOT affect the transfer in progress.

Reset
REQ-015 While clear=1 at an edge, the block SHALL set state to IDLE, cnt to 0 and the latched word, direction and length to 0.
REQ-016 While clear=1, sreg_clear SHALL be 1; otherwise sreg_clear SHALL be 0.
REQ-017 Reset mid-transfer SHALL abandon the transfer with no done pulse; all outputs SHALL be 0 on the cycle after reset.

Configuration
REQ-018 With SHIFT_SEQ_ROTATE_EN defined, the injected bit SHALL be the exiting bit (sl=q_msb when shifting left, sr=q_lsb when shifting right), so that 32 shifts restore the original word; the fill port SHALL be ignored.
REQ-019 Without SHIFT_SEQ_ROTATE_EN, the fill port SHALL be used as described in REQ-008.

Structure
REQ-020 A shared package SHALL hold the state enum, the mode constants MODE_HOLD, MODE_RIGHT, MODE_LEFT and MODE_LOAD, and the width constant WORD_W=32.
REQ-021 The block SHALL be a single module with no sub-module; the integration test SHALL instantiate it together with the existing 32-bit 194-based shift register.

Verification
REQ-022 The bench SHALL cover these scenarios:
  - Reset: clear held for 2 cycles mid-SHIFT -> IDLE, s1s0=00, sreg_clear=1 during reset, no done pulse.
  - Right shift: data_in=0x0000_00A5, len=7, dir_left=0, fill=0 -> ser_out sequence 1,0,1,0,0,1,0,1; done at start+10; register = 0x0000_0000.
  - Left shift: data_in=0x8000_0001, len=31, fill=1 -> first ser_out=1; register = 0xFFFF_FFFF after done.
  - Rotate (macro on): data_in=0x1234_5678, len=31, right -> register = 0x1234_5678 at done.
  - Abort and start together at the 3rd SHIFT cycle -> IDLE next cycle, no done, start ignored; a new start one cycle later is accepted.
  - Start pulsed during busy -> ignored; exactly one done pulse per accepted start.
